common_cross_arbiter4_rr: RTL
=============================

# common_cross_arbiter4_rr

Registered 4-to-1 round-robin cross arbiter with packet lock. It shares one downstream valid/ready channel among four upstream requesters, and a multi-beat packet is never interleaved with another port's beats. It sits beside the 2-to-1 priority cross buffer and is used wherever fairness matters more than fixed priority, such as merging cache-refill, uncached and page-walk request streams onto one memory port.

## Interface
Parameters:
- BUFFER_WIDTH, 1: payload width per beat.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- prevN_i_data (N=0..3), input, BUFFER_WIDTH: payload from requester N.
- prevN_i_last, input, 1: marks the final beat of a packet; a single-beat packet has last=1.
- prevN_i_valid, input, 1: requester N offers a beat.
- prevN_o_ready, output, 1: beat from N is accepted this cycle.
- next_o_data, output, BUFFER_WIDTH: registered payload.
- next_o_last, output, 1: registered last flag.
- next_o_port, output, 2: index of the source port of the current output beat.
- next_o_valid, output, 1: output register holds a beat.
- next_i_ready, input, 1: downstream accepts.

## Operation
- Output stage is a one-entry register (full, data, last, port).
  - can_load = ~full | next_i_ready.
  - At most one prevN_o_ready is high per cycle. It is high only for the granted port, and only when can_load is 1 and reset is deasserted.
- State machine: IDLE and LOCKED, plus a 2-bit lock_port register.
- IDLE:
  - Grant goes to the first valid port, scanning from ptr+1 upward modulo 4.
  - ptr is the last granted port.
  - On an accepted beat with last=1: ptr := granted port, and the state stays IDLE.
  - On an accepted beat with last=0: ptr := granted port, lock_port := granted port, state goes to LOCKED.
- LOCKED:
  - Only lock_port is eligible; other valid ports see ready=0.
  - If lock_port drops valid, no grant is issued. The lock holds indefinitely with no timeout.
  - An accepted beat with last=1 returns the state to IDLE.
- Round-robin fairness: with all four ports continuously offering single-beat packets, grants rotate 0,1,2,3,0,…
- Upstream data is passed unmodified. next_o_port carries the granted index.
- Once next_o_valid rises, the output beat stays stable until next_i_ready is seen.

## Timing
- Reset values:
  - next_o_valid=0.
  - next_o_data=0, next_o_last=0, next_o_port=0.
  - state=IDLE, ptr=3, so port 0 has first priority after reset. lock_port=0.
  - All prevN_o_ready=0 while reset is low.
- Latency is 1 cycle. A beat accepted at edge k appears on next_o_* after edge k.
- Throughput is 1 beat/cycle. Simultaneous output drain and input load in the same cycle is required.
- prevN_o_ready is combinational from valid inputs, state, ptr, full and next_i_ready. There is no combinational path from prevN_i_data to any output.
- Reset asserted mid-packet: the lock is cleared, the output register is emptied, and the in-flight beat is dropped. The upstream must restart the packet.
- next_i_ready=0 with full=1: every prevN_o_ready is 0, and state and ptr are frozen.
- Grant pointer wrap-around: ptr=3 scans 0,1,2,3.

## Structure
- Shared package constants:
  - ARB4_PORT_W=2.
  - State encoding ARB_IDLE=1'b0, ARB_LOCKED=1'b1.
- Sub-module common_arbiter4_rr_grant (combinational).
  - Inputs: 4-bit request vector and 2-bit ptr.
  - Outputs: one-hot grant, grant index, and any_grant.
  - Reusable by other round-robin schedulers.
- The top level holds the FSM, ptr, lock_port, and the output register. Target size is about 200 lines.

## Test plan
- Reset release: hold reset low for 3 cycles with all ports valid. All readys must stay 0 and next_o_valid must stay 0. The first grant after release must go to port 0; the next three must go to 1, 2, 3.
- Rotation: ports 1 and 3 valid with single beats and next_i_ready=1.
  - next_o_port must be 1,3,1,3.
  - Data must match source values, e.g. port1=0x11 and port3=0x33 at BUFFER_WIDTH=8.
- Packet lock:
  - Port 2 sends 3 beats (last on the third). Port 0 is continuously valid.
  - Output must be 2,2,2 and then 0.
  - Port 0 ready must be 0 during beats 1-3.
- Lock with bubble: port 1 drops valid for 2 cycles after beat 1 of a 2-beat packet. No grant may be issued to ports 0/2/3 until beat 2 with last=1 is accepted.
- Backpressure: next_i_ready=0 for 4 cycles with a beat held.
  - next_o_data and next_o_port must be stable, and all readys must be 0.
  - On release there must be back-to-back beats with no lost cycle.
- Mid-packet reset: assert reset after beat 1 of a 3-beat packet from port 3.
  - next_o_valid must drop immediately (asynchronous).
  - After release, port 0 is granted first, even with port 3 still valid.

Source files
------------

// File: rtl/common_cross_arbiter4_rr_pkg.sv
// Shared constants and types for the 4-port round-robin cross arbiter.
// Also hosts small helpers reused by other round-robin schedulers.
package common_cross_arbiter4_rr_pkg;

    localparam int ARB4_PORTS  = 4;
    localparam int ARB4_PORT_W = 2;

    typedef logic [ARB4_PORT_W-1:0] arb4_port_t;
    typedef logic [ARB4_PORTS-1:0]  arb4_vec_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic arb4_vec_t arb4_onehot(input arb4_port_t idx);
        arb4_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/common_arbiter4_rr_grant.sv
// Combinational 4-way round-robin grant: first request after ptr wins.
// Scans ptr+1, ptr+2, ptr+3, ptr (mod 4).
module common_arbiter4_rr_grant
    import common_cross_arbiter4_rr_pkg::*;
(
    input  arb4_vec_t  req,
    input  arb4_port_t ptr,
    output arb4_vec_t  gnt,
    output arb4_port_t gnt_idx,
    output logic       any_grant
);

    always_comb begin : scan
        arb4_port_t cand;
        gnt       = '0;
        gnt_idx   = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int i = 1; i <= ARB4_PORTS; i++) begin
            // 2-bit add wraps naturally, so i=4 lands back on ptr
            cand = ptr + arb4_port_t'(i);
            if (!any_grant && req[cand]) begin
                any_grant = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (any_grant) begin
            gnt = arb4_onehot(gnt_idx);
        end
    end

endmodule

// File: rtl/common_cross_arbiter4_rr.sv
// Registered 4-to-1 round-robin cross arbiter with multi-beat packet lock.
// One-entry output register; drains and reloads in the same cycle.
module common_cross_arbiter4_rr
    import common_cross_arbiter4_rr_pkg::*;
#(
    parameter int BUFFER_WIDTH = 1
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUFFER_WIDTH-1:0] prev0_i_data,
    input  logic                    prev0_i_last,
    input  logic                    prev0_i_valid,
    output logic                    prev0_o_ready,
    input  logic [BUFFER_WIDTH-1:0] prev1_i_data,
    input  logic                    prev1_i_last,
    input  logic                    prev1_i_valid,
    output logic                    prev1_o_ready,
    input  logic [BUFFER_WIDTH-1:0] prev2_i_data,
    input  logic                    prev2_i_last,
    input  logic                    prev2_i_valid,
    output logic                    prev2_o_ready,
    input  logic [BUFFER_WIDTH-1:0] prev3_i_data,
    input  logic                    prev3_i_last,
    input  logic                    prev3_i_valid,
    output logic                    prev3_o_ready,
    output logic [BUFFER_WIDTH-1:0] next_o_data,
    output logic                    next_o_last,
    output arb4_port_t              next_o_port,
    output logic                    next_o_valid,
    input  logic                    next_i_ready
);

    logic [BUFFER_WIDTH-1:0] in_data [ARB4_PORTS];
    arb4_vec_t               in_valid;
    arb4_vec_t               in_last;

    assign in_data[0] = prev0_i_data;
    assign in_data[1] = prev1_i_data;
    assign in_data[2] = prev2_i_data;
    assign in_data[3] = prev3_i_data;

    assign in_valid = {prev3_i_valid, prev2_i_valid,
                       prev1_i_valid, prev0_i_valid};
    assign in_last  = {prev3_i_last, prev2_i_last,
                       prev1_i_last, prev0_i_last};

    arb_state_e state_q, state_d;
    arb4_port_t ptr_q, ptr_d;
    arb4_port_t lock_q, lock_d;

    logic                    full_q;
    logic [BUFFER_WIDTH-1:0] data_q;
    logic                    last_q;
    arb4_port_t              port_q;

    logic       can_load;
    arb4_vec_t  req;
    arb4_vec_t  gnt;
    arb4_port_t gnt_idx;
    logic       any_grant;
    logic       accept;
    logic       sel_last;
    arb4_vec_t  ready_vec;

    assign can_load = ~full_q | next_i_ready;

    // While locked only the owner of the open packet may request
    assign req = (state_q == ARB_LOCKED)
               ? (in_valid & arb4_onehot(lock_q))
               : in_valid;

    common_arbiter4_rr_grant u_grant (
        .req       (req),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .any_grant (any_grant)
    );

    assign accept    = any_grant & can_load & reset;
    assign ready_vec = gnt & {ARB4_PORTS{can_load & reset}};
    assign sel_last  = in_last[gnt_idx];

    assign prev0_o_ready = ready_vec[0];
    assign prev1_o_ready = ready_vec[1];
    assign prev2_o_ready = ready_vec[2];
    assign prev3_o_ready = ready_vec[3];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (accept) begin
            ptr_d = gnt_idx;
            unique case (state_q)
                ARB_IDLE: begin
                    if (!sel_last) begin
                        state_d = ARB_LOCKED;
                        lock_d  = gnt_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (sel_last) begin
                        state_d = ARB_IDLE;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= arb4_port_t'(ARB4_PORTS - 1);
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            port_q <= '0;
        end else if (accept) begin
            full_q <= 1'b1;
            data_q <= in_data[gnt_idx];
            last_q <= sel_last;
            port_q <= gnt_idx;
        end else if (next_i_ready) begin
            full_q <= 1'b0;
        end
    end

    assign next_o_valid = full_q;
    assign next_o_data  = data_q;
    assign next_o_last  = last_q;
    assign next_o_port  = port_q;

endmodule
